// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and serial line between the byte controller and the UART transmitter.
// The controller drives data/request; the transmitter drives readiness and the line.
interface uart_tx_serializer_if;
   logic [7:0] TX_data;
   logic       TX_en;
   logic       TX_status;
   logic       uart_tx;

   modport master (
      output TX_data,
      output TX_en,
      input  TX_status,
      input  uart_tx
   );

   modport slave (
      input  TX_data,
      input  TX_en,
      output TX_status,
      output uart_tx
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: accepts a byte while idle, sends start, 8 data bits LSB first, stop.
// The line and the ready flag are registered so they only move on bit-period boundaries.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int CNT_W        = 14
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   uart_tx_serializer_if.slave  tx_if
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [7:0]       r_shift;
   logic             r_tx;
   logic             r_status;
   logic             w_bit_end;

   assign w_bit_end       = (r_cnt == LP_CNT_LAST);
   assign tx_if.uart_tx   = r_tx;
   assign tx_if.TX_status = r_status;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
         r_status <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Accept edge: the start bit begins on this same edge
               if (tx_if.TX_en) begin
                  r_shift  <= tx_if.TX_data;
                  r_tx     <= 1'b0;
                  r_status <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_tx    <= r_shift[0];
                  r_idx   <= '0;
                  r_state <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     // Next bit is shift[1] before the shift lands
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                     r_idx   <= r_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt    <= '0;
                  r_status <= 1'b1;
                  r_state  <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_cnt    <= '0;
               r_tx     <= 1'b1;
               r_status <= 1'b1;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
